// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state codes, stage-control struct and constants for pipeline_hazard_ctrl
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN = '{
        pc_en:        1'b1,
        pc_sel:       1'b0,
        if_id_en:     1'b1,
        id_ex_en:     1'b1,
        ex_mem_en:    1'b1,
        mem_wb_en:    1'b1,
        if_id_flush:  1'b0,
        id_ex_flush:  1'b0,
        ex_mem_flush: 1'b0,
        mem_wb_flush: 1'b0
    };

endpackage

// File: rtl/hazard_wait_timer.sv
// rtl/hazard_wait_timer.sv - consecutive data-memory wait counter with timeout compare
module hazard_wait_timer #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    output logic at_limit
);

    logic [CNT_W-1:0] cnt;

    // The count only survives across back-to-back wait cycles; any other cycle restarts it.
    always_ff @(posedge clk) begin
        if (!resetn || !inc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage stall/flush sequencer; optional HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        mem_branch,
    input  logic        mem_zero,
    input  logic        mem_memacc,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic [1:0]  state_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        timeout_err
);

    import hazard_pkg::*;

    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_LU_STALL = LU_STALL;
    localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    stage_ctrl_t ctrl;
    logic        req;
    logic        lu_haz;
    logic        br_tk;
    logic        mwait;
    logic        at_limit;
    logic        timeout;
    logic        err_q;

    assign lu_haz  = ex_memread & (ex_rd != REG_X0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign br_tk   = mem_branch & mem_zero;
    assign mwait   = mem_memacc & ~dmem_ready;
    assign timeout = (state == ST_MEM_WAIT) & mwait & at_limit;

    hazard_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .resetn   (reset),
        .inc      (mwait & ~timeout),
        .at_limit (at_limit)
    );

    // Decisions depend only on live inputs; state matters just for the timeout check,
    // so encoding 3 naturally behaves like RUN.
    always_comb begin
        ctrl      = CTRL_RUN;
        req       = mem_memacc;
        state_nxt = ST_RUN;
        if (!reset) begin
            req = 1'b0;
        end else if (mwait) begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_en    = 1'b0;
            ctrl.mem_wb_flush = 1'b1;
            if (timeout) begin
                ctrl.ex_mem_flush = 1'b1;
                req               = 1'b0;
            end else begin
                state_nxt = ST_MEM_WAIT;
            end
        end else if (br_tk) begin
            ctrl.pc_sel       = 1'b1;
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
        end else if (lu_haz) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
            state_nxt        = ST_LU_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_en && perf_stall_cyc != 32'hFFFF_FFFF) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (ctrl.pc_sel && perf_flush_cnt != 32'hFFFF_FFFF) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

    assign dmem_req     = req;
    assign pc_en        = ctrl.pc_en;
    assign pc_sel       = ctrl.pc_sel;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign state_o      = state;
    assign timeout_err  = err_q;

endmodule
